// File: rtl/logic_op_issue.sv
// logic_op_issue: command FIFO in front of a combinational 4-bit logical
// unit, with a registered, back-pressurable result stage.
module logic_op_issue #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  input  logic [1:0]       in_Opcode,
  output logic [WIDTH-1:0] op_A,
  output logic [WIDTH-1:0] op_B,
  output logic [1:0]       op_Opcode,
  input  logic [WIDTH-1:0] logical_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [1:0]       out_Opcode,
  output logic             out_zero,
  output logic [AW:0]      fifo_count,
  output logic [15:0]      done_count
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

  localparam logic [AW:0] LP_DEPTH = (AW+1)'(DEPTH);

  // Command storage; contents are don't-care after reset.
  logic [WIDTH-1:0] r_mem_a  [DEPTH];
  logic [WIDTH-1:0] r_mem_b  [DEPTH];
  logic [1:0]       r_mem_op [DEPTH];

  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_result;
  logic [1:0]       r_res_op;
  logic             r_zero;
  logic [15:0]      r_done;

  logic w_push;
  logic w_fire;
  logic w_hs;
  logic w_out_valid;

  assign w_out_valid = (r_state == ST_FULL);
  // in_ready looks at registered occupancy only, never at a same-cycle pop.
  assign in_ready    = (r_count != LP_DEPTH);
  assign w_push      = in_valid && in_ready;
  assign w_fire      = (r_count != {(AW+1){1'b0}}) && (!w_out_valid || out_ready);
  assign w_hs        = w_out_valid && out_ready;

  assign out_valid   = w_out_valid;
  assign out_result  = r_result;
  assign out_Opcode  = r_res_op;
  assign out_zero    = r_zero;
  assign fifo_count  = r_count;
  assign done_count  = r_done;

  // Present the FIFO head to the logical unit, zeros when nothing is queued.
  always_comb begin
    op_A      = {WIDTH{1'b0}};
    op_B      = {WIDTH{1'b0}};
    op_Opcode = 2'b00;
    if (r_count != {(AW+1){1'b0}}) begin
      op_A      = r_mem_a[r_rd_ptr];
      op_B      = r_mem_b[r_rd_ptr];
      op_Opcode = r_mem_op[r_rd_ptr];
    end else begin
      op_A      = {WIDTH{1'b0}};
      op_B      = {WIDTH{1'b0}};
      op_Opcode = 2'b00;
    end
  end

  // Write accepted commands into storage.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= in_A;
      r_mem_b[r_wr_ptr]  <= in_B;
      r_mem_op[r_wr_ptr] <= in_Opcode;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= {AW{1'b0}};
      r_rd_ptr <= {AW{1'b0}};
      r_count  <= {(AW+1){1'b0}};
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_fire) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_fire})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Output register state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Output register next state: load on fire, drain on handshake, else hold.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_EMPTY: begin
        if (w_fire) w_state_nxt = ST_FULL;
        else        w_state_nxt = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_fire)         w_state_nxt = ST_FULL;
        else if (out_ready) w_state_nxt = ST_EMPTY;
        else                w_state_nxt = ST_FULL;
      end
      default: w_state_nxt = ST_EMPTY;
    endcase
  end

  // Capture the logical unit's result; values hold when not firing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result <= {WIDTH{1'b0}};
      r_res_op <= 2'b00;
      r_zero   <= 1'b0;
    end else if (w_fire) begin
      r_result <= logical_in;
      r_res_op <= r_mem_op[r_rd_ptr];
      r_zero   <= (logical_in == {WIDTH{1'b0}});
    end
  end

  // Count completed output handshakes, wrapping at 2^16.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_done <= 16'd0;
    end else if (w_hs) begin
      r_done <= r_done + 16'd1;
    end
  end

endmodule

// File: tb/tb_logic_op_issue.sv
// Scoreboard bench for logic_op_issue with a behavioural logical unit.
module tb_logic_op_issue;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_A, in_B;
  logic [1:0] in_Opcode;
  logic [3:0] op_A, op_B;
  logic [1:0] op_Opcode;
  logic [3:0] logical_in;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_result;
  logic [1:0] out_Opcode;
  logic       out_zero;
  logic [2:0] fifo_count;
  logic [15:0] done_count;

  logic_op_issue #(.WIDTH(4), .DEPTH(4), .AW(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .in_Opcode(in_Opcode),
    .op_A(op_A), .op_B(op_B), .op_Opcode(op_Opcode),
    .logical_in(logical_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_Opcode(out_Opcode), .out_zero(out_zero),
    .fifo_count(fifo_count), .done_count(done_count)
  );

  always #5 clk = ~clk;

  // Reference logical-unit behaviour, bit by bit.
  function automatic logic [3:0] ref_logic(input logic [3:0] a, input logic [3:0] b,
                                           input logic [1:0] op);
    logic [3:0] r;
    for (int i = 0; i < 4; i++) begin
      case (op)
        2'b00:   r[i] = a[i] & b[i];
        2'b01:   r[i] = a[i] | b[i];
        2'b10:   r[i] = a[i] ^ b[i];
        default: r[i] = ~(a[i] | b[i]);
      endcase
    end
    return r;
  endfunction

  // The external combinational logical unit.
  always_comb logical_in = ref_logic(op_A, op_B, op_Opcode);

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] res;
  } exp_t;

  exp_t        sb[$];
  int          m_fifo;
  bit          m_outv;
  logic [15:0] m_done;
  bit          m_en = 1'b0;
  int          n_cmp = 0;
  int          n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: occupancy, accepted command list and handshake count.
  always @(posedge clk) begin
    bit fire, push, hs;
    if (rst) begin
      sb.delete();
      m_fifo = 0;
      m_outv = 1'b0;
      m_done = 16'd0;
      m_en   = 1'b1;
    end else if (m_en) begin
      fire = (m_fifo > 0) && (!m_outv || out_ready);
      push = in_valid && (m_fifo != 4);
      hs   = m_outv && out_ready;
      if (hs) m_done = m_done + 16'd1;
      if (push) sb.push_back('{a: in_A, b: in_B, op: in_Opcode,
                               res: ref_logic(in_A, in_B, in_Opcode)});
      m_fifo = m_fifo + (push ? 1 : 0) - (fire ? 1 : 0);
      if (fire)    m_outv = 1'b1;
      else if (hs) m_outv = 1'b0;
    end
  end

  // Monitor: compare DUT against the model away from the active edge.
  always @(negedge clk) begin
    exp_t h;
    int   hi;
    if (m_en) begin
      chk("fifo_count", 32'(fifo_count), 32'(m_fifo));
      chk("in_ready", 32'(in_ready), 32'(m_fifo != 4));
      chk("out_valid", 32'(out_valid), 32'(m_outv));
      chk("done_count", 32'(done_count), 32'(m_done));
      if (m_fifo > 0) begin
        hi = m_outv ? 1 : 0;
        if (sb.size() > hi) begin
          h = sb[hi];
          chk("op_head", {20'd0, op_A, op_B, 2'd0, op_Opcode}, {20'd0, h.a, h.b, 2'd0, h.op});
        end else begin
          chk("head_missing", 32'(sb.size()), 32'(hi + 1));
        end
      end else begin
        chk("op_idle", {22'd0, op_A, op_B, op_Opcode}, 32'd0);
      end
      if (m_outv) begin
        if (sb.size() > 0) begin
          h = sb[0];
          chk("out_result", 32'(out_result), 32'(h.res));
          chk("out_Opcode", 32'(out_Opcode), 32'(h.op));
          chk("out_zero", 32'(out_zero), 32'(h.res == 4'd0));
          if (out_ready && !rst) void'(sb.pop_front());
        end else begin
          chk("sb_empty", 32'(out_valid), 32'd0);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input bit v, input logic [3:0] a, input logic [3:0] b, input logic [1:0] op);
    in_valid  = v;
    in_A      = a;
    in_B      = b;
    in_Opcode = op;
  endtask

  initial begin
    int waited;
    rst = 1'b1;
    out_ready = 1'b1;
    drv(1'b1, 4'b1111, 4'b0101, 2'b01);
    cyc();
    cyc();
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_done", 32'(done_count), 32'd0);
    rst = 1'b0;
    drv(1'b0, 4'd0, 4'd0, 2'd0);
    cyc();

    // Single operation, latency and done_count.
    drv(1'b1, 4'b1100, 4'b1010, 2'b00);
    cyc();
    drv(1'b0, 4'd0, 4'd0, 2'd0);
    cyc();
    @(negedge clk);
    chk("single_valid", 32'(out_valid), 32'd1);
    chk("single_result", 32'(out_result), 32'b1000);
    chk("single_zero", 32'(out_zero), 32'd0);
    cyc();
    @(negedge clk);
    chk("single_done", 32'(done_count), 32'd1);

    // Back-to-back, all four opcodes.
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 4'b1100, 4'b1010, 2'(i));
      cyc();
    end
    drv(1'b0, 4'd0, 4'd0, 2'd0);
    repeat (3) cyc();
    @(negedge clk);
    chk("b2b_done", 32'(done_count), 32'd5);

    // Backpressure: six offered, five held.
    out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drv(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      cyc();
    end
    drv(1'b0, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    chk("bp_fifo_full", 32'(fifo_count), 32'd4);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    repeat (3) cyc();
    out_ready = 1'b1;
    repeat (6) cyc();
    @(negedge clk);
    chk("bp_drained", 32'(fifo_count), 32'd0);
    chk("bp_done", 32'(done_count), 32'd10);

    // Zero-flag cases.
    drv(1'b1, 4'b0011, 4'b1100, 2'b00); cyc();
    drv(1'b1, 4'b1111, 4'b0000, 2'b11); cyc();
    drv(1'b1, 4'b0101, 4'b0101, 2'b10); cyc();
    drv(1'b0, 4'd0, 4'd0, 2'd0);
    repeat (3) cyc();

    // Reset mid-operation.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drv(1'b1, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      cyc();
    end
    drv(1'b0, 4'd0, 4'd0, 2'd0);
    @(negedge clk);
    chk("mid_fifo", 32'(fifo_count), 32'd3);
    chk("mid_valid", 32'(out_valid), 32'd1);
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_fifo", 32'(fifo_count), 32'd0);
    chk("mid_rst_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_done", 32'(done_count), 32'd0);
    out_ready = 1'b1;
    repeat (4) cyc();

    // Randomised traffic with occasional reset.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 99) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      drv(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
          4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      cyc();
    end
    rst = 1'b0;
    out_ready = 1'b1;
    drv(1'b0, 4'd0, 4'd0, 2'd0);

    // Bounded drain.
    waited = 0;
    while ((m_fifo != 0 || m_outv) && waited < 50) begin
      cyc();
      waited++;
    end
    if (waited >= 50) chk("drain_timeout", 32'(waited), 32'd0);
    cyc();
    @(negedge clk);
    chk("final_fifo", 32'(fifo_count), 32'd0);
    chk("final_valid", 32'(out_valid), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/logic_op_issue.md
Name: logic_op_issue

Overview:
- Sequencing stage directly upstream of the team's 4-bit logical unit. The logical unit is combinational: operands A, B, a 2-bit Opcode, result logical_out.
- Buffers incoming (A, B, Opcode) commands in a small FIFO and drives the head entry onto the logical unit's inputs.
- Captures the returned logical_out into a registered output with valid/ready handshake, zero flag and completion counter, giving the combinational unit a clocked, back-pressurable interface.

Parameters:
WIDTH, 4, operand/result width; must match the logical unit's A/B/logical_out width
DEPTH, 4, command FIFO depth; power of 2, >= 2
AW, 2, log2(DEPTH)

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous active-high reset
in_valid  input  1  command valid
in_ready  output  1  FIFO can accept a command
in_A  input  WIDTH  operand A
in_B  input  WIDTH  operand B
in_Opcode  input  2  00 AND, 01 OR, 10 XOR, 11 NOR
op_A  output  WIDTH  to logical unit A
op_B  output  WIDTH  to logical unit B
op_Opcode  output  2  to logical unit Opcode
logical_in  input  WIDTH  from logical unit logical_out
out_valid  output  1  result register holds a result
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  registered result
out_Opcode  output  2  opcode that produced out_result
out_zero  output  1  out_result == 0
fifo_count  output  AW+1  entries in FIFO (0..DEPTH)
done_count  output  16  completed output handshakes, wraps at 2^16

Behaviour:
- One clock (clk), synchronous active-high reset (rst); all state updates on rising edge of clk.
- Reset (sampled high on an edge): clears FIFO pointers, fifo_count, out_valid, out_result, out_Opcode, out_zero and done_count to 0.
  - Queued and in-flight commands are discarded.
  - Reset mid-operation produces no further results.
  - FIFO storage contents are don't-care.
- push = in_valid && in_ready.
  - in_ready = (fifo_count != DEPTH), decoded from registers only; it does not depend on a same-cycle pop.
  - in_valid while in_ready = 0 is ignored; the command is lost unless held by the producer.
- op_A/op_B/op_Opcode: combinational from the FIFO head entry when fifo_count > 0; all zero when empty.
- Output register FSM, two states:
  - EMPTY (out_valid = 0)
  - FULL (out_valid = 1)
- fire = (fifo_count > 0) && (!out_valid || out_ready).
- On fire:
  - out_result <= logical_in
  - out_Opcode <= head opcode
  - out_zero <= (logical_in == 0)
  - out_valid <= 1
  - FIFO pops head
- out_valid && out_ready && !fire: out_valid <= 0 (FULL -> EMPTY); out_result, out_Opcode and out_zero hold their last values.
- out_valid && !out_ready: output register and FIFO head hold; out_result, out_Opcode and out_zero stay stable.
- Handshake on out_valid && out_ready: done_count <= done_count + 1, modulo 2^16.
- fifo_count update:
  - push && fire: unchanged
  - push only: +1
  - fire only: -1
- Pointers wrap modulo DEPTH.
- Latency: command accepted on edge k appears on out_valid after edge k+1, when the FIFO was empty and the output was free.
- Throughput: one result per cycle with out_ready held high.
- Ordering: results leave in strict acceptance order.
- Capacity under stall: DEPTH + 1 commands (DEPTH in FIFO, 1 in output register).

Test Plan:
- Reset: assert rst for 2 edges with in_valid = 1 -> in_ready = 1, out_valid = 0, fifo_count = 0, done_count = 0; nothing is pushed while rst is high.
- Single op: A = 1100, B = 1010, Opcode = 00 accepted on edge k, out_ready = 1 -> after edge k+1 out_valid = 1, out_result = 1000, out_Opcode = 00, out_zero = 0; done_count = 1 after edge k+2.
- Back-to-back: push (1100,1010,00), (1100,1010,01), (1100,1010,10), (1100,1010,11) on consecutive cycles, out_ready = 1 -> out_result 1000, 1110, 0110, 0001 on consecutive cycles; done_count = 4.
- Backpressure: out_ready = 0, offer 6 commands -> 5 accepted (1 in output register, fifo_count = 4), in_ready = 0, out_result stable. Then raise out_ready -> remaining 5 drain in order, one per cycle; final fifo_count = 0.
- Zero flag: (0011,1100,00) -> out_result = 0000, out_zero = 1. (1111,0000,11) -> out_result = 0000, out_zero = 1. (0101,0101,10) -> out_result = 0000, out_zero = 1.
- Reset mid-operation: 3 queued, out_valid = 1, assert rst one edge -> fifo_count = 0, out_valid = 0, done_count = 0; no stale results afterwards.
